spectrum_bar_renderer: RTL and testbench
========================================

Name: spectrum_bar_renderer

Overview:
- Graphics stage directly upstream of the VGA timing generator in the audio visualizer.
- Consumes the VGA block's hc/vc counters and a band-magnitude write port from the spectrum analyzer.
- Produces 8-bit colour (3R/3G/2B) per pixel: NBANDS vertical bars with colour zones and a peak-hold marker per band.
- Magnitudes are double-buffered and committed once per frame during vertical blanking, so the display never tears mid-frame.

Parameters:
- NBANDS, 16, number of bars; bar index width is 4 bits.
- MAG_W, 6, magnitude width; range 0..63.
- BAR_W, 40, pixel columns per band slot; NBANDS*BAR_W = 640.
- BAR_GAP, 4, black columns at the right edge of each slot.
- UNIT_H, 7, pixel rows per magnitude unit; 63*7 = 441 < 480.
- PEAK_HOLD, 30, frames the peak is held before decay starts.
- PEAK_ROWS, 2, height of the peak marker in rows.

Ports:
- vgaclk, in, 1, pixel clock (25 MHz).
- rst, in, 1, asynchronous active-high reset.
- hc, in, 10, horizontal counter from the VGA block (0..799).
- vc, in, 10, vertical counter from the VGA block (0..524).
- band_wr_en, in, 1, write strobe for the shadow magnitude bank.
- band_wr_idx, in, 4, band index; writes with idx >= NBANDS are ignored.
- band_wr_mag, in, MAG_W, magnitude to write.
- red_out, out, 3, pixel red.
- green_out, out, 3, pixel green.
- blue_out, out, 2, pixel blue.
- upd_busy, out, 1, high while the per-frame commit sequence runs.
- frame_tick, out, 1, one-cycle pulse on the last cycle of the commit.

Behaviour:
- Reset (asynchronous, active-high): clears shadow, active and peak banks; clears hold counters; clears column and band counters; state = IDLE; all outputs = 0.
- Shadow bank write: on band_wr_en, shadow[idx] <= mag on the next edge. Writes are accepted in any state.
- Commit FSM states: IDLE, COMMIT.
  - IDLE -> COMMIT when hc==0 && vc==480; k = 0.
  - COMMIT handles band k per cycle, k = 0..NBANDS-1.
  - On the last band: frame_tick = 1 for that cycle, then state returns to IDLE.
  - upd_busy = 1 exactly during COMMIT, for NBANDS cycles.
- Per-band commit action:
  - active[k] <= shadow[k], using the value present before any same-cycle write to shadow[k]; that write lands and is committed next frame.
  - If shadow[k] >= peak[k]: peak <= shadow[k], hold <= 0.
  - Else if hold < PEAK_HOLD: hold++.
  - Else: peak <= peak - 1, hold unchanged. peak - 1 >= shadow[k] always holds, so there is no underflow.
- Column tracking: counters only, no divider.
  - hc==0: col <= 0, band <= 0.
  - Otherwise col++; when col == BAR_W-1, col <= 0 and band++, saturating at NBANDS.
- Pixel rule, evaluated for the current (hc, vc):
  - Active region: hc < 640 && vc < 480 && band < NBANDS && col < BAR_W-BAR_GAP. Outside it, colour = 0.
  - fill_top = 480 - active[band]*UNIT_H.
  - peak_top = 480 - peak[band]*UNIT_H.
  - Peak marker: peak > 0 && vc >= peak_top && vc < peak_top + PEAK_ROWS. Colour = (7,7,3).
  - Bar: vc >= fill_top && active > 0. Colour by row: vc < 160 red (7,0,0); vc < 320 yellow (7,7,0); otherwise green (0,7,0).
  - Priority: peak marker > bar > black.
- Output latency: colour outputs are registered, 1 cycle. The colour computed at (hc, vc) appears while the VGA block is at hc+1.
  - The image is shifted right by one pixel; column 639's colour falls in blanking.
  - This offset is accepted and fixed.
- Arithmetic widths: mag*UNIT_H is computed at 10 bits; all comparisons are unsigned at 10 bits.
- Reset mid-COMMIT: the FSM returns to IDLE, banks clear, and no frame_tick is issued.

Test Plan:
- Reset, then run one frame with no writes -> all colour outputs 0 every cycle; upd_busy high 16 cycles starting at hc=0,vc=480; exactly one frame_tick.
- Write band 3 = 10 -> next frame: hc 121..156 (display one cycle later) on rows 410..479 are green. Rows 410..411 are white as the peak marker (peak = 10, marker wins). Other bands are black.
- Band 0 = 63 -> rows 39..40 white; rows 41..159 red; rows 160..319 yellow; rows 320..479 green. Columns 36..39 (gap) stay black.
- Band 5 = 20 then 0 -> peak holds at 20 for 30 frames. It then decrements by 1 per frame and reaches 0 after a further 20 frames. The marker disappears when peak = 0.
- Write band 2 = 9 on the same cycle COMMIT processes band 2 (old shadow 4) -> this frame displays 4; the next frame displays 9.
- Assert rst at the 8th COMMIT cycle -> outputs 0 immediately; upd_busy 0; no frame_tick; the next frame commits from a cleared state.

Source files
------------

// File: rtl/spectrum_bar_if.sv
// rtl/spectrum_bar_if.sv - VGA counter, magnitude write and pixel colour bundle for the bar renderer
interface spectrum_bar_if #(
    parameter int MAG_W = 6
);
    logic [9:0]       hc;
    logic [9:0]       vc;
    logic             band_wr_en;
    logic [3:0]       band_wr_idx;
    logic [MAG_W-1:0] band_wr_mag;
    logic [2:0]       red_out;
    logic [2:0]       green_out;
    logic [1:0]       blue_out;
    logic             upd_busy;
    logic             frame_tick;

    modport master (
        output hc, vc, band_wr_en, band_wr_idx, band_wr_mag,
        input  red_out, green_out, blue_out, upd_busy, frame_tick
    );

    modport slave (
        input  hc, vc, band_wr_en, band_wr_idx, band_wr_mag,
        output red_out, green_out, blue_out, upd_busy, frame_tick
    );
endinterface

// File: rtl/spectrum_bar_renderer.sv
// rtl/spectrum_bar_renderer.sv - double-buffered spectrum bar renderer with peak-hold markers
module spectrum_bar_renderer #(
    parameter int NBANDS    = 16,
    parameter int MAG_W     = 6,
    parameter int BAR_W     = 40,
    parameter int BAR_GAP   = 4,
    parameter int UNIT_H    = 7,
    parameter int PEAK_HOLD = 30,
    parameter int PEAK_ROWS = 2
) (
    input  logic           vgaclk,
    input  logic           rst,
    spectrum_bar_if.slave  bus
);
    localparam logic [7:0]       C_PEAK  = 8'b111_111_11;
    localparam logic [7:0]       C_RED   = 8'b111_000_00;
    localparam logic [7:0]       C_YEL   = 8'b111_111_00;
    localparam logic [7:0]       C_GRN   = 8'b000_111_00;
    localparam logic [MAG_W-1:0] MAG_ONE = 1;

    typedef enum logic {IDLE, COMMIT} state_t;

    state_t           state, state_nxt;
    logic [3:0]       k;
    logic             upd_busy, frame_tick;

    logic [MAG_W-1:0] shadow [NBANDS];
    logic [MAG_W-1:0] active [NBANDS];
    logic [MAG_W-1:0] peak   [NBANDS];
    logic [4:0]       hold   [NBANDS];

    logic [5:0]       col;
    logic [4:0]       band;
    logic [7:0]       colour, colour_nxt;

    always_ff @(posedge vgaclk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
        end else begin
            state <= state_nxt;
            k     <= (state == COMMIT) ? k + 4'd1 : 4'd0;
        end
    end

    always_comb begin
        state_nxt  = state;
        upd_busy   = 1'b0;
        frame_tick = 1'b0;
        case (state)
            IDLE: begin
                if (bus.hc == 10'd0 && bus.vc == 10'd480)
                    state_nxt = COMMIT;
            end
            COMMIT: begin
                upd_busy = 1'b1;
                if (k == 4'(NBANDS - 1)) begin
                    frame_tick = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Commit reads shadow[k] before any same-edge write lands, so a racing write waits a frame.
    always_ff @(posedge vgaclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NBANDS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
                peak[i]   <= '0;
                hold[i]   <= '0;
            end
        end else begin
            if (bus.band_wr_en && int'(bus.band_wr_idx) < NBANDS)
                shadow[bus.band_wr_idx] <= bus.band_wr_mag;
            if (state == COMMIT) begin
                active[k] <= shadow[k];
                if (shadow[k] >= peak[k]) begin
                    peak[k] <= shadow[k];
                    hold[k] <= '0;
                end else if (hold[k] < 5'(PEAK_HOLD)) begin
                    hold[k] <= hold[k] + 5'd1;
                end else begin
                    peak[k] <= peak[k] - MAG_ONE;
                end
            end
        end
    end

    always_ff @(posedge vgaclk or posedge rst) begin
        if (rst) begin
            col  <= '0;
            band <= '0;
        end else if (bus.hc == 10'd0) begin
            col  <= '0;
            band <= '0;
        end else if (col == 6'(BAR_W - 1)) begin
            col <= '0;
            if (band != 5'(NBANDS))
                band <= band + 5'd1;
        end else begin
            col <= col + 6'd1;
        end
    end

    logic [MAG_W-1:0] cur_act, cur_pk;
    logic [9:0]       fill_top, peak_top;
    logic             in_region, peak_hit, bar_hit;

    always_comb begin
        cur_act    = active[band[3:0]];
        cur_pk     = peak[band[3:0]];
        fill_top   = 10'd480 - 10'(cur_act) * 10'(UNIT_H);
        peak_top   = 10'd480 - 10'(cur_pk) * 10'(UNIT_H);
        in_region  = (bus.hc < 10'd640) && (bus.vc < 10'd480) &&
                     (band < 5'(NBANDS)) && (col < 6'(BAR_W - BAR_GAP));
        peak_hit   = (cur_pk != '0) && (bus.vc >= peak_top) &&
                     (bus.vc < peak_top + 10'(PEAK_ROWS));
        bar_hit    = (cur_act != '0) && (bus.vc >= fill_top);
        colour_nxt = 8'd0;
        if (in_region) begin
            if (peak_hit)
                colour_nxt = C_PEAK;
            else if (bar_hit)
                colour_nxt = (bus.vc < 10'd160) ? C_RED :
                             (bus.vc < 10'd320) ? C_YEL : C_GRN;
        end
    end

    always_ff @(posedge vgaclk or posedge rst) begin
        if (rst)
            colour <= '0;
        else
            colour <= colour_nxt;
    end

    assign bus.red_out    = colour[7:5];
    assign bus.green_out  = colour[4:2];
    assign bus.blue_out   = colour[1:0];
    assign bus.upd_busy   = upd_busy;
    assign bus.frame_tick = frame_tick;
endmodule

// File: tb/tb_spectrum_bar_renderer.sv
// tb/tb_spectrum_bar_renderer.sv - directed bench for the spectrum bar renderer
module tb_spectrum_bar_renderer;
    logic vgaclk = 1'b0;
    logic rst;

    spectrum_bar_if #(.MAG_W(6)) bus();

    spectrum_bar_renderer dut (
        .vgaclk (vgaclk),
        .rst    (rst),
        .bus    (bus)
    );

    always #20 vgaclk = ~vgaclk;

    int n_tests = 0;
    int n_fail  = 0;
    int act_m[16];
    int pk_m[16];
    int busy_cnt, tick_cnt;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pix();
        return int'({bus.red_out, bus.green_out, bus.blue_out});
    endfunction

    // Colour expected after presenting (h, v); the column counters lag hc by one.
    function automatic int exp_pix(input int h, input int v);
        int c, b, cl, ft, pt;
        if (h < 1 || h >= 640 || v >= 480) return 0;
        c  = h - 1;
        b  = c / 40;
        cl = c % 40;
        if (cl >= 36) return 0;
        pt = 480 - pk_m[b] * 7;
        ft = 480 - act_m[b] * 7;
        if (pk_m[b] > 0 && v >= pt && v < pt + 2) return 8'hFF;
        if (act_m[b] > 0 && v >= ft) begin
            if (v < 160) return 8'hE0;
            if (v < 320) return 8'hFC;
            return 8'h1C;
        end
        return 0;
    endfunction

    task automatic tick(input int h, input int v);
        bus.hc = 10'(h);
        bus.vc = 10'(v);
        @(posedge vgaclk);
        @(negedge vgaclk);
    endtask

    task automatic wr(input int idx, input int mag);
        bus.band_wr_en  = 1'b1;
        bus.band_wr_idx = 4'(idx);
        bus.band_wr_mag = 6'(mag);
        tick(700, 500);
        bus.band_wr_en  = 1'b0;
    endtask

    task automatic commit_frame(input int wr_hc, input int wr_idx, input int wr_mag, input int rst_hc);
        busy_cnt = 0;
        tick_cnt = 0;
        for (int h = 0; h < 20; h++) begin
            if (h == wr_hc) begin
                bus.band_wr_en  = 1'b1;
                bus.band_wr_idx = 4'(wr_idx);
                bus.band_wr_mag = 6'(wr_mag);
            end
            tick(h, 480);
            bus.band_wr_en = 1'b0;
            busy_cnt += int'(bus.upd_busy);
            tick_cnt += int'(bus.frame_tick);
            if (h == rst_hc) begin
                rst = 1'b1;
                #1;
                check("mid_rst_colour", pix(), 0);
                check("mid_rst_busy", int'(bus.upd_busy), 0);
                check("mid_rst_tick", int'(bus.frame_tick), 0);
            end
        end
        rst = 1'b0;
    endtask

    task automatic check_row(input int v, input string tag);
        for (int h = 0; h < 660; h++) begin
            tick(h, v);
            if (h >= 1)
                check($sformatf("%s_h%0d_v%0d", tag, h, v), pix(), exp_pix(h, v));
        end
    endtask

    task automatic probe(input int h, input int v, input string tag);
        for (int i = 0; i <= h; i++) tick(i, v);
        check($sformatf("%s_h%0d_v%0d", tag, h, v), pix(), exp_pix(h, v));
    endtask

    initial begin
        rst             = 1'b1;
        bus.hc          = '0;
        bus.vc          = '0;
        bus.band_wr_en  = 1'b0;
        bus.band_wr_idx = '0;
        bus.band_wr_mag = '0;
        for (int i = 0; i < 16; i++) begin
            act_m[i] = 0;
            pk_m[i]  = 0;
        end
        repeat (3) @(negedge vgaclk);
        check("rst_colour", pix(), 0);
        check("rst_busy", int'(bus.upd_busy), 0);
        check("rst_tick", int'(bus.frame_tick), 0);
        rst = 1'b0;

        commit_frame(-1, 0, 0, -1);
        check("idle_busy_cycles", busy_cnt, 16);
        check("idle_ticks", tick_cnt, 1);
        check_row(0, "empty");
        check_row(479, "empty");

        wr(3, 10);
        commit_frame(-1, 0, 0, -1);
        act_m[3] = 10; pk_m[3] = 10;
        check_row(409, "b3");
        check_row(410, "b3");
        check_row(411, "b3");
        check_row(412, "b3");
        check_row(479, "b3");

        wr(0, 63);
        commit_frame(-1, 0, 0, -1);
        act_m[0] = 63; pk_m[0] = 63;
        check_row(38, "b0");
        check_row(39, "b0");
        check_row(40, "b0");
        check_row(41, "b0");
        check_row(159, "b0");
        check_row(160, "b0");
        check_row(319, "b0");
        check_row(320, "b0");

        wr(2, 4);
        commit_frame(-1, 0, 0, -1);
        act_m[2] = 4; pk_m[2] = 4;
        commit_frame(3, 2, 9, -1);
        probe(90, 452, "race_old_peak");
        probe(90, 440, "race_old_fill");
        commit_frame(-1, 0, 0, -1);
        act_m[2] = 9; pk_m[2] = 9;
        probe(90, 440, "race_new_fill");
        probe(90, 417, "race_new_peak");

        wr(5, 20);
        commit_frame(-1, 0, 0, -1);
        act_m[5] = 20; pk_m[5] = 20;
        wr(5, 0);
        for (int f = 1; f <= 50; f++) begin
            commit_frame(-1, 0, 0, -1);
            act_m[5] = 0;
            pk_m[5]  = (f <= 30) ? 20 : 20 - (f - 30);
            if (pk_m[5] > 0) begin
                probe(210, 480 - pk_m[5] * 7, $sformatf("decay_f%0d", f));
                probe(210, 479 - pk_m[5] * 7, $sformatf("decay_above_f%0d", f));
            end else begin
                probe(210, 479, $sformatf("decay_gone_f%0d", f));
            end
        end

        commit_frame(-1, 0, 0, 7);
        check("rst_commit_busy", busy_cnt, 8);
        check("rst_commit_ticks", tick_cnt, 0);
        for (int i = 0; i < 16; i++) begin
            act_m[i] = 0;
            pk_m[i]  = 0;
        end
        commit_frame(-1, 0, 0, -1);
        check("post_rst_busy", busy_cnt, 16);
        check("post_rst_ticks", tick_cnt, 1);
        check_row(39, "post_rst");
        check_row(479, "post_rst");
        wr(7, 3);
        commit_frame(-1, 0, 0, -1);
        act_m[7] = 3; pk_m[7] = 3;
        check_row(459, "b7");
        check_row(470, "b7");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
